// File: rtl/pipelined_addsub_unit_pkg.sv
// Shared op encodings, stage count and block-count derivation for pipelined_addsub_unit.
// Pure declarations: no logic, no latency, no backpressure.
package pipelined_addsub_unit_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int NUM_STAGES = 3;

  function automatic int num_blocks(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/addsub_pipe_ctrl.sv
// Per-stage valid and load enables for a bubble-collapsing STAGES-deep pipeline.
// A stage loads when empty or when its successor loads; the last stage stalls on !out_ready.
module addsub_pipe_ctrl #(
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              v_in,
  input  logic              out_ready,
  output logic              in_ready,
  output logic [STAGES-1:0] load,
  output logic [STAGES-1:0] vld
);

  always_comb begin
    logic nxt;
    nxt = !vld[STAGES-1] || out_ready;
    load = '0;
    load[STAGES-1] = nxt;
    for (int k = STAGES - 2; k >= 0; k--) begin
      nxt     = !vld[k] || nxt;
      load[k] = nxt;
    end
  end

  assign in_ready = load[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld <= (load & {vld[STAGES-2:0], v_in}) | (~load & vld);
    end
  end

endmodule

// File: rtl/cs_block.sv
// Carry-select block: both candidate sums plus block generate/propagate; combinational.
// No state, no backpressure.
module cs_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK-1:0] sum0,
  output logic [BLOCK-1:0] sum1,
  output logic             g,
  output logic             p
);

  logic [BLOCK:0] raw0;

  assign raw0 = {1'b0, a} + {1'b0, b};
  assign sum0 = raw0[BLOCK-1:0];
  assign sum1 = raw0[BLOCK-1:0] + BLOCK'(1);
  assign g    = raw0[BLOCK];
  // Carry-in ripples through only when every bit pair propagates.
  assign p    = &(a ^ b);

endmodule

// File: rtl/parallel_prefix_tree.sv
// Kogge-Stone prefix over block G/P giving the carry into each block and the final carry out.
// Combinational, no backpressure.
module parallel_prefix_tree #(
  parameter int N = 4
) (
  input  logic [N-1:0] g,
  input  logic [N-1:0] p,
  input  logic         cin,
  output logic [N:0]   carry
);

  always_comb begin
    logic [N-1:0] gg;
    logic [N-1:0] pp;
    logic [N-1:0] ng;
    logic [N-1:0] np;
    gg = g;
    pp = p;
    ng = '0;
    np = '0;
    for (int d = 1; d < N; d = d * 2) begin
      ng = gg;
      np = pp;
      for (int i = d; i < N; i++) begin
        ng[i] = gg[i] | (pp[i] & gg[i-d]);
        np[i] = pp[i] & pp[i-d];
      end
      gg = ng;
      pp = np;
    end
    carry[0] = cin;
    for (int i = 0; i < N; i++) begin
      carry[i+1] = gg[i] | (pp[i] & cin);
    end
  end

endmodule

// File: rtl/pipelined_addsub_unit.sv
// Carry-select add/sub, 3 stages (block sums, prefix carries, select); latency 3, 1 result/cycle.
// Valid/ready with in-place stall on !out_ready; `define ADDSUB_FLAGS_EN adds zero/neg/ovf flags.
module pipelined_addsub_unit
  import pipelined_addsub_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             v_in,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             v_out,
  input  logic             out_ready,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NUM_BLOCKS = num_blocks(WIDTH, BLOCK);

  if ((WIDTH % BLOCK) != 0 || NUM_BLOCKS < 2) begin : g_bad_cfg
    $error("pipelined_addsub_unit: WIDTH must be a multiple of BLOCK with at least 2 blocks");
  end

  logic [NUM_STAGES-1:0] load;
  logic [NUM_STAGES-1:0] vld;

  addsub_pipe_ctrl #(.STAGES(NUM_STAGES)) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .v_in      (v_in),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .load      (load),
    .vld       (vld)
  );

  assign v_out = vld[NUM_STAGES-1];

  // Subtract is a + ~b + ~cin, so borrow-in folds into the carry-in.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  assign b_eff   = (op == OP_SUB) ? ~b : b;
  assign cin_eff = (op == OP_SUB) ? ~cin : cin;

  logic [NUM_BLOCKS-1:0][BLOCK-1:0] blk_sum0, blk_sum1;
  logic [NUM_BLOCKS-1:0]            blk_g, blk_p;

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_blk
    cs_block #(.BLOCK(BLOCK)) u_blk (
      .a    (a[i*BLOCK +: BLOCK]),
      .b    (b_eff[i*BLOCK +: BLOCK]),
      .sum0 (blk_sum0[i]),
      .sum1 (blk_sum1[i]),
      .g    (blk_g[i]),
      .p    (blk_p[i])
    );
  end

  logic [NUM_BLOCKS-1:0][BLOCK-1:0] s1_sum0, s1_sum1, s2_sum0, s2_sum1;
  logic [NUM_BLOCKS-1:0]            s1_g, s1_p;
  logic                             s1_cin;
  logic [NUM_BLOCKS:0]              tree_carry, s2_carry;

  always_ff @(posedge clk) begin
    if (load[0]) begin
      s1_sum0 <= blk_sum0;
      s1_sum1 <= blk_sum1;
      s1_g    <= blk_g;
      s1_p    <= blk_p;
      s1_cin  <= cin_eff;
    end
    if (load[1]) begin
      s2_sum0  <= s1_sum0;
      s2_sum1  <= s1_sum1;
      s2_carry <= tree_carry;
    end
  end

  parallel_prefix_tree #(.N(NUM_BLOCKS)) u_tree (
    .g     (s1_g),
    .p     (s1_p),
    .cin   (s1_cin),
    .carry (tree_carry)
  );

  logic [WIDTH-1:0] sel_sum;
  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_sel
    assign sel_sum[i*BLOCK +: BLOCK] = s2_carry[i] ? s2_sum1[i] : s2_sum0[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (load[2]) begin
      sum  <= sel_sum;
      cout <= s2_carry[NUM_BLOCKS];
    end
  end

`ifdef ADDSUB_FLAGS_EN
  logic s1_a_msb, s1_b_msb, s2_a_msb, s2_b_msb;

  always_ff @(posedge clk) begin
    if (load[0]) begin
      s1_a_msb <= a[WIDTH-1];
      s1_b_msb <= b_eff[WIDTH-1];
    end
    if (load[1]) begin
      s2_a_msb <= s1_a_msb;
      s2_b_msb <= s1_b_msb;
    end
  end

  // Overflow: effective operands share a sign that the result does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
      neg  <= 1'b0;
      ovf  <= 1'b0;
    end else if (load[2]) begin
      zero <= (sel_sum == '0);
      neg  <= sel_sum[WIDTH-1];
      ovf  <= (s2_a_msb == s2_b_msb) && (sel_sum[WIDTH-1] != s2_a_msb);
    end
  end
`else
  assign zero = 1'b0;
  assign neg  = 1'b0;
  assign ovf  = 1'b0;
`endif

endmodule
